// File: rtl/jk_cmd_debounce_pkg.sv
// Shared types and defaults for the J/K command debouncer.
package jk_cmd_pkg;

   // Per-channel debounce state; encoding is fixed so bit 1 means "debounced level is high".
   typedef enum logic [1:0] {
      DB_RELEASED     = 2'd0,
      DB_PRESS_WAIT   = 2'd1,
      DB_PRESSED      = 2'd2,
      DB_RELEASE_WAIT = 2'd3
   } db_state_e;

   localparam int DEBOUNCE_CYCLES_DFLT = 4;

endpackage

// File: rtl/jk_cmd_debounce_if.sv
// Button inputs and J/K request outputs of the debouncer, bundled for port lists.
interface jk_cmd_debounce_if;
   logic btn_on;
   logic btn_off;
   logic j;
   logic k;
   logic on_level;
   logic off_level;

   modport master (
      output btn_on, btn_off,
      input  j, k, on_level, off_level
   );

   modport slave (
      input  btn_on, btn_off,
      output j, k, on_level, off_level
   );
endinterface

// File: rtl/jk_cmd_debounce_btn_debounce.sv
// One button channel: 2-flop synchronizer, 4-state debounce FSM with a
// saturating qualification counter, debounced level and a one-cycle press strobe.
//
// state           | meaning
// ----------------+-----------------------------------------------------
// DB_RELEASED     | debounced low, synced input low
// DB_PRESS_WAIT   | debounced low, counting consecutive high samples
// DB_PRESSED      | debounced high, synced input high
// DB_RELEASE_WAIT | debounced high, counting consecutive low samples
module btn_debounce
   import jk_cmd_pkg::*;
#(
   parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
   localparam int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic areset_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    r_sync;
   db_state_e     r_state;
   db_state_e     w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_press;
   logic          w_press_nxt;
   logic          w_sync;

   assign w_sync = r_sync[1];

   // Two-flop synchronizer for the raw asynchronous button.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) r_sync <= 2'b00;
      else           r_sync <= {r_sync[0], i_btn};
   end

   // State, counter and press strobe registers.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         r_state <= DB_RELEASED;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_press <= w_press_nxt;
      end
   end

   // Next-state and counter logic; the counter stops at CNT_LAST so it cannot wrap.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         DB_RELEASED: begin
            if (w_sync) begin
               w_state_nxt = DB_PRESS_WAIT;
               w_cnt_nxt   = CW'(1);
            end
         end
         DB_PRESS_WAIT: begin
            if (!w_sync) begin
               w_state_nxt = DB_RELEASED;
               w_cnt_nxt   = '0;
            end else if (r_cnt >= CNT_LAST) begin
               w_state_nxt = DB_PRESSED;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CW'(1);
            end
         end
         DB_PRESSED: begin
            if (!w_sync) begin
               w_state_nxt = DB_RELEASE_WAIT;
               w_cnt_nxt   = CW'(1);
            end
         end
         DB_RELEASE_WAIT: begin
            if (w_sync) begin
               w_state_nxt = DB_PRESSED;
               w_cnt_nxt   = '0;
            end else if (r_cnt >= CNT_LAST) begin
               w_state_nxt = DB_RELEASED;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = DB_RELEASED;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Strobe only on a qualified press; a bounce back from RELEASE_WAIT is not a new press.
   assign w_press_nxt = (r_state == DB_PRESS_WAIT) && (w_state_nxt == DB_PRESSED);

   assign o_level = (r_state == DB_PRESSED) || (r_state == DB_RELEASE_WAIT);
   assign o_press = r_press;

endmodule

// File: rtl/jk_cmd_debounce.sv
// Two debounced buttons turned into J (go ON) / K (go OFF) request pulses.
// OFF wins: an off press, or the off button being held, suppresses J.
module jk_cmd_debounce
   import jk_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
   input logic              clk,
   input logic              areset_n,
   jk_cmd_debounce_if.slave bus
);

   logic w_on_level;
   logic w_on_press;
   logic w_off_level;
   logic w_off_press;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_on (
      .clk      (clk),
      .areset_n (areset_n),
      .i_btn    (bus.btn_on),
      .o_level  (w_on_level),
      .o_press  (w_on_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_off (
      .clk      (clk),
      .areset_n (areset_n),
      .i_btn    (bus.btn_off),
      .o_level  (w_off_level),
      .o_press  (w_off_press)
   );

   assign bus.j         = w_on_press & ~w_off_press & ~w_off_level;
   assign bus.k         = w_off_press;
   assign bus.on_level  = w_on_level;
   assign bus.off_level = w_off_level;

endmodule

// File: tb/tb_jk_cmd_debounce.sv
// Bench for jk_cmd_debounce: directed scenarios plus random bouncing stimulus,
// checked against a sample-history model of the debounce rule.
module tb_jk_cmd_debounce;
   import jk_cmd_pkg::*;

   localparam int N = DEBOUNCE_CYCLES_DFLT;

   logic clk      = 1'b0;
   logic areset_n = 1'b0;

   always #5 clk = ~clk;

   jk_cmd_debounce_if bus();

   jk_cmd_debounce #(.DEBOUNCE_CYCLES(N)) dut (
      .clk      (clk),
      .areset_n (areset_n),
      .bus      (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: raw samples per edge; the debounced level flips when the N synced
   // samples used at this edge (raw samples two edges old) all disagree with it.
   bit h_on[$];
   bit h_off[$];
   bit m_on_lvl, m_off_lvl, m_on_pr, m_off_pr;

   task automatic model_reset();
      h_on.delete();
      h_off.delete();
      for (int i = 0; i < N + 2; i++) begin
         h_on.push_back(1'b0);
         h_off.push_back(1'b0);
      end
      m_on_lvl = 0; m_off_lvl = 0; m_on_pr = 0; m_off_pr = 0;
   endtask

   task automatic model_step(input bit on, input bit off);
      bit flip_on, flip_off;
      h_on.push_back(on);
      h_off.push_back(off);
      if (h_on.size() > N + 2)  void'(h_on.pop_front());
      if (h_off.size() > N + 2) void'(h_off.pop_front());
      flip_on  = 1'b1;
      flip_off = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (h_on[i]  == m_on_lvl)  flip_on  = 1'b0;
         if (h_off[i] == m_off_lvl) flip_off = 1'b0;
      end
      m_on_pr  = flip_on  && !m_on_lvl;
      m_off_pr = flip_off && !m_off_lvl;
      if (flip_on)  m_on_lvl  = !m_on_lvl;
      if (flip_off) m_off_lvl = !m_off_lvl;
   endtask

   // Per-scenario bookkeeping, counted in edges since clear_counts.
   int  edge_idx, nj, nk, first_j, first_k, fall_edge;
   bit  prev_on;

   task automatic clear_counts();
      edge_idx = 0; nj = 0; nk = 0; first_j = 0; first_k = 0; fall_edge = 0;
   endtask

   // Called at a negedge: apply inputs, take one rising edge, compare, return at the next negedge.
   task automatic tick(input bit on, input bit off);
      bit exp_j;
      bus.btn_on  = on;
      bus.btn_off = off;
      @(posedge clk);
      model_step(on, off);
      #1;
      edge_idx++;
      exp_j = m_on_pr && !m_off_pr && !m_off_lvl;
      chk("on_level",  bus.on_level,  m_on_lvl);
      chk("off_level", bus.off_level, m_off_lvl);
      chk("j",         bus.j,         exp_j);
      chk("k",         bus.k,         m_off_pr);
      chk("jk_excl",   bus.j & bus.k, 0);
      if (bus.j === 1'b1) begin nj++; if (first_j == 0) first_j = edge_idx; end
      if (bus.k === 1'b1) begin nk++; if (first_k == 0) first_k = edge_idx; end
      if (prev_on && bus.on_level === 1'b0 && fall_edge == 0) fall_edge = edge_idx;
      prev_on = (bus.on_level === 1'b1);
      @(negedge clk);
   endtask

   task automatic do_reset();
      areset_n = 1'b0;
      #1;
      chk("rst_j",   bus.j, 0);
      chk("rst_k",   bus.k, 0);
      chk("rst_on",  bus.on_level, 0);
      chk("rst_off", bus.off_level, 0);
      @(posedge clk);
      #1;
      chk("rst_hold_j",  bus.j | bus.k, 0);
      chk("rst_hold_lv", bus.on_level | bus.off_level, 0);
      model_reset();
      prev_on = 1'b0;
      @(negedge clk);
      areset_n = 1'b1;
   endtask

   initial begin
      int rate;
      bit r_on, r_off;
      bus.btn_on  = 1'b0;
      bus.btn_off = 1'b0;
      prev_on     = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Held on button: one J at edge N+2, no K.
      clear_counts();
      for (int i = 0; i < 12; i++) tick(1, 0);
      chk("s1_nj", nj, 1);
      chk("s1_first_j", first_j, N + 2);
      chk("s1_nk", nk, 0);
      chk("s1_on_level", bus.on_level, 1);
      for (int i = 0; i < 10; i++) tick(0, 0);

      // Bounce 1,0,1,0 then hold: J counted from the first stable edge (edge 5).
      clear_counts();
      tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
      for (int i = 0; i < 12; i++) tick(1, 0);
      chk("s2_nj", nj, 1);
      chk("s2_first_j", first_j, 4 + N + 2);
      for (int i = 0; i < 10; i++) tick(0, 0);

      // Simultaneous presses: K once, never J.
      clear_counts();
      for (int i = 0; i < 12; i++) tick(1, 1);
      chk("s3_nk", nk, 1);
      chk("s3_first_k", first_k, N + 2);
      chk("s3_nj", nj, 0);
      for (int i = 0; i < 10; i++) tick(0, 0);

      // Off held, then on pressed, then off released: no J at all.
      clear_counts();
      for (int i = 0; i < 10; i++) tick(0, 1);
      chk("s4_nk", nk, 1);
      clear_counts();
      for (int i = 0; i < 10; i++) tick(1, 1);
      chk("s4_nj_held", nj, 0);
      chk("s4_on_level", bus.on_level, 1);
      for (int i = 0; i < 10; i++) tick(1, 0);
      chk("s4_nj_rel", nj, 0);
      chk("s4_off_level", bus.off_level, 0);
      for (int i = 0; i < 10; i++) tick(0, 0);

      // Reset mid-qualification aborts; held button re-qualifies afterwards.
      clear_counts();
      for (int i = 0; i < 3; i++) tick(1, 0);
      chk("s5_nj_pre", nj, 0);
      bus.btn_on = 1'b1;
      do_reset();
      clear_counts();
      for (int i = 0; i < 12; i++) tick(1, 0);
      chk("s5_nj", nj, 1);
      chk("s5_first_j", first_j, N + 2);

      // Long hold then release: one J, level falls N+2 edges after release.
      for (int i = 0; i < 10; i++) tick(0, 0);
      clear_counts();
      for (int i = 0; i < 1000; i++) tick(1, 0);
      chk("s6_nj", nj, 1);
      clear_counts();
      for (int i = 0; i < 12; i++) tick(0, 0);
      chk("s6_fall_edge", fall_edge, N + 2);
      chk("s6_nj_rel", nj, 0);
      chk("s6_nk", nk, 0);

      // Random bouncing with varying toggle rate and occasional resets.
      r_on = 0; r_off = 0;
      for (int blk = 0; blk < 20; blk++) begin
         rate = $urandom_range(1, 40);
         if ($urandom_range(0, 4) == 0) begin
            bus.btn_on  = r_on;
            bus.btn_off = r_off;
            do_reset();
         end
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 99) < rate) r_on  = !r_on;
            if ($urandom_range(0, 99) < rate) r_off = !r_off;
            tick(r_on, r_off);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
